// File: rtl/drive_cmd_tx_if.sv
// Command/serial bundle between the driving-mode logic and the UART command transmitter.
interface drive_cmd_tx_if;
    logic       power;
    logic [1:0] global_state;
    logic [3:0] moving_state;
    logic       tx;
    logic       busy;
    logic       frame_done;

    // Transmitter side: takes the command fields, drives the serial line and status.
    modport slave (
        input  power, global_state, moving_state,
        output tx, busy, frame_done
    );

    // Command source side.
    modport master (
        output power, global_state, moving_state,
        input  tx, busy, frame_done
    );
endinterface

// File: rtl/drive_cmd_tx.sv
// UART 8N1 command transmitter: packs power/global_state/moving_state into one byte
// and sends it whenever it changes, plus a periodic keep-alive copy.
module drive_cmd_tx #(
    parameter int CLKS_PER_BIT   = 10416,
    parameter int REFRESH_CYCLES = 2_000_000
) (
    input  logic            sys_clk,
    input  logic            rst,
    drive_cmd_tx_if.slave   bus
);
    localparam int BW = (CLKS_PER_BIT   > 1) ? $clog2(CLKS_PER_BIT)   : 1;
    localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [RW-1:0] REF_LAST  = RW'(REFRESH_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          r_state;
    logic [7:0]      r_last_sent;
    logic            r_pend;
    logic [RW-1:0]   r_refresh_cnt;
    logic [BW-1:0]   r_baud_cnt;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;
    logic            r_tx;
    logic            r_busy;
    logic            r_frame_done;

    logic [7:0]      w_cmd;
    logic            w_refresh_hit;
    logic            w_want;
    logic            w_baud_last;

    // Command byte and send request; a reverted change compares equal and sends nothing.
    always_comb begin
        w_cmd         = bus.power ? {1'b0, bus.global_state, 1'b1, bus.moving_state} : 8'h00;
        w_refresh_hit = (r_refresh_cnt == REF_LAST);
        w_want        = r_pend | w_refresh_hit | (w_cmd != r_last_sent);
        w_baud_last   = (r_baud_cnt == BAUD_LAST);
    end

    // Keep-alive timer, free-running regardless of the line state.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) r_refresh_cnt <= '0;
        else if (w_refresh_hit) r_refresh_cnt <= '0;
        else r_refresh_cnt <= r_refresh_cnt + 1'b1;
    end

    // Frame FSM; pend starts set so a frame goes out right after reset.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_last_sent  <= 8'h00;
            r_pend       <= 1'b1;
            r_baud_cnt   <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_tx         <= 1'b1;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            // A keep-alive tick during a frame is remembered and served on return to IDLE.
            if (r_state != IDLE && w_refresh_hit) r_pend <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (w_want) begin
                        r_shift     <= w_cmd;
                        r_last_sent <= w_cmd;
                        r_pend      <= 1'b0;
                        r_tx        <= 1'b0;
                        r_busy      <= 1'b1;
                        r_baud_cnt  <= '0;
                        r_state     <= START;
                    end
                end
                START: begin
                    if (w_baud_last) begin
                        r_baud_cnt <= '0;
                        r_tx       <= r_shift[0];
                        r_bit_idx  <= '0;
                        r_state    <= DATA;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (w_baud_last) begin
                        r_baud_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= STOP;
                        end else begin
                            r_shift   <= r_shift >> 1;
                            r_bit_idx <= r_bit_idx + 1'b1;
                            r_tx      <= r_shift[1];
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (w_baud_last) begin
                        r_baud_cnt   <= '0;
                        r_busy       <= 1'b0;
                        r_frame_done <= 1'b1;
                        r_state      <= IDLE;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.tx         = r_tx;
    assign bus.busy       = r_busy;
    assign bus.frame_done = r_frame_done;
endmodule

// File: tb/tb_drive_cmd_tx.sv
// Bench for drive_cmd_tx: stimulus pushes expected bytes, a line monitor decodes frames
// and pops/compares; frame start cycles are checked against a hand-computed schedule.
module tb_drive_cmd_tx;
    localparam int CPB = 4;
    localparam int REF = 1000;

    logic sys_clk;
    logic rst;
    int   cyc;
    int   n_cmp;
    int   n_bad;
    logic [7:0] exp_q[$];
    int   starts[$];

    drive_cmd_tx_if bus();

    drive_cmd_tx #(.CLKS_PER_BIT(CPB), .REFRESH_CYCLES(REF)) dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .bus     (bus)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Edge counter since the last reset release: first edge after release is 1.
    always @(posedge sys_clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else cyc <= cyc + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_n(input int n, inout bit ab);
        for (int i = 0; i < n && !ab; i++) begin
            @(negedge sys_clk);
            if (!rst) ab = 1'b1;
        end
    endtask

    task automatic wait_cyc(input int n);
        int g;
        g = 0;
        while (cyc < n) begin
            @(negedge sys_clk);
            g++;
            if (g > 20000) begin
                $display("FAIL wait_cyc: timed out at %0d waiting for %0d", cyc, n);
                $fatal(1);
            end
        end
    endtask

    // Line monitor: samples mid-bit, pops the expected byte at the end of each frame.
    initial begin
        forever begin
            @(negedge sys_clk);
            if (rst === 1'b1 && bus.tx === 1'b0) begin
                bit ab;
                logic [7:0] d;
                logic [7:0] e;
                logic s0, s1, fd, bz, bz0;
                ab = 1'b0;
                d  = 8'h00;
                starts.push_back(cyc);
                wait_n(2, ab);
                s0 = bus.tx; bz0 = bus.busy;
                for (int i = 0; i < 8; i++) begin
                    wait_n(4, ab);
                    d[i] = bus.tx;
                end
                wait_n(4, ab);
                s1 = bus.tx;
                wait_n(2, ab);
                fd = bus.frame_done; bz = bus.busy;
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_frame: got byte 0x%0h with no expected byte", d);
                end else begin
                    e = exp_q.pop_front();
                    if (!ab) begin
                        chk("frame_byte", int'(d), int'(e));
                        chk("framing_start_busy_stop", int'({s0, bz0, s1}), 3'b011);
                        chk("frame_done_busy_low", int'({fd, bz}), 2'b10);
                    end
                end
            end
        end
    end

    // Directed stimulus.
    initial begin
        int exp_starts[12];
        exp_starts = '{1, 1000, 2000, 3000, 3041, 4000, 4101, 4201, 5000, 1, 1000, 2000};
        n_cmp = 0; n_bad = 0;
        rst = 1'b0;
        bus.power = 1'b1; bus.global_state = 2'b01; bus.moving_state = 4'b0001;
        #12;
        chk("reset_tx", int'(bus.tx), 1);
        chk("reset_busy", int'(bus.busy), 0);
        chk("reset_frame_done", int'(bus.frame_done), 0);
        // First frame + two keep-alives + the one carrying the in-flight changes.
        repeat (4) exp_q.push_back(8'h31);
        @(negedge sys_clk);
        rst = 1'b1;

        // Changes during the 3000 frame: 0x34, back to 0x31, then 0x38.
        wait_cyc(3010); bus.moving_state = 4'b0100;
        wait_cyc(3020); bus.moving_state = 4'b0001;
        wait_cyc(3030); bus.moving_state = 4'b1000;
        exp_q.push_back(8'h38);   // after frame_done
        exp_q.push_back(8'h38);   // keep-alive at 4000

        // Power drop while idle, then power back with a new mode.
        wait_cyc(4100);
        bus.power = 1'b0;
        exp_q.push_back(8'h00);
        wait_cyc(4200);
        bus.power = 1'b1; bus.global_state = 2'b10; bus.moving_state = 4'b0000;
        exp_q.push_back(8'h50);

        // Keep-alive at 5000 is aborted by reset at frame cycle 17, then resent.
        exp_q.push_back(8'h50);
        exp_q.push_back(8'h50);
        wait_cyc(5017);
        chk("busy_before_reset", int'(bus.busy), 1);
        #2 rst = 1'b0;
        #1;
        chk("async_reset_tx", int'(bus.tx), 1);
        chk("async_reset_busy", int'(bus.busy), 0);
        repeat (3) @(negedge sys_clk);
        rst = 1'b1;

        // Change and keep-alive in the same IDLE cycle: one frame, then next at 2000.
        wait_cyc(999);
        bus.global_state = 2'b11; bus.moving_state = 4'b0010;
        exp_q.push_back(8'h72);
        exp_q.push_back(8'h72);
        wait_cyc(2300);

        chk("expected_left_over", exp_q.size(), 0);
        chk("frame_count", starts.size(), 12);
        for (int i = 0; i < 12; i++) begin
            if (i < starts.size()) chk($sformatf("start_cycle_%0d", i), starts[i], exp_starts[i]);
            else chk($sformatf("start_cycle_%0d_missing", i), -1, exp_starts[i]);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/drive_cmd_tx.md
# drive_cmd_tx

Serial command transmitter for the car link. It takes the `moving_state` command produced by the driving-mode controllers, together with `power` and `global_state`, and packs them into one command byte. The byte goes out on a UART 8N1 line to the car/simulator, which is the other end of the link that returns `detector` readings. A byte is sent whenever the command changes, and also periodically as a keep-alive.

## Interface
- `CLKS_PER_BIT`, default 10416: `sys_clk` cycles per UART bit (100 MHz / 9600 baud); must be ≥ 2.
- `REFRESH_CYCLES`, default 2_000_000: keep-alive period in `sys_clk` cycles (20 ms); must be ≥ 2.

- `sys_clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `power`  in  1  car power; 0 forces the command byte to 0x00.
- `global_state`  in  2  current driving mode.
- `moving_state`  in  4  command, one bit each: forward=0001, back=0010, left=0100, right=1000, stop=0000.
- `tx`  out  1  UART serial output; idles high.
- `busy`  out  1  high while a frame is on the line.
- `frame_done`  out  1  one-cycle pulse after each stop bit completes.

## Operation
- Command byte `cmd`:
  - power=1: `{1'b0, global_state, 1'b1, moving_state}`.
  - power=0: 8'h00.
  - `cmd` is combinational from the inputs.
- Registers:
  - `last_sent[7:0]`
  - `pend` (1 bit)
  - `refresh_cnt`: 0..REFRESH_CYCLES-1, wraps.
  - `baud_cnt`: 0..CLKS_PER_BIT-1.
  - `bit_idx[2:0]`
  - `shift[7:0]`
- `refresh_cnt` free-runs in every state. Its terminal value is `refresh_hit`.
- `want = pend | refresh_hit | (cmd != last_sent)`.
- FSM states IDLE, START, DATA, STOP:
  - IDLE: tx=1, busy=0. If `want`: shift<=cmd, last_sent<=cmd, pend<=0, tx<=0, busy<=1, baud_cnt<=0, go START.
  - START: tx=0. When baud_cnt=CLKS_PER_BIT-1: tx<=shift[0], bit_idx<=0, go DATA.
  - DATA: sends bits LSB first. Each time baud_cnt=CLKS_PER_BIT-1:
    - if bit_idx=7: tx<=1, go STOP;
    - else: shift right, bit_idx+1, tx<=next bit.
  - STOP: tx=1. When baud_cnt=CLKS_PER_BIT-1: busy<=0, frame_done<=1, go IDLE.
- `baud_cnt` resets to 0 on every bit boundary.
- Outside IDLE, `refresh_hit` sets `pend`.
- A `cmd` change during a frame does not alter the frame in flight. On return to IDLE, the comparison with `last_sent` sends the newest value. Several changes in one frame collapse to the last one.
- A command that changes and then reverts to `last_sent` within one frame produces no extra frame.
- `refresh_hit` in the same IDLE cycle as a change produces one frame, not two.
- `moving_state` values are passed through unvalidated; multi-bit values are sent as-is.

## Timing
- Reset values: tx=1, busy=0, frame_done=0, state=IDLE, last_sent=8'h00, pend=1, refresh_cnt=0, baud_cnt=0, bit_idx=0, shift=0.
- Because pend=1 after reset, the first frame starts on the first clock edge after `rst` deasserts.
- Latency: `cmd` change visible before edge N in IDLE → tx low from edge N.
- Bit lengths: the start bit, each data bit and the stop bit each last exactly CLKS_PER_BIT cycles. A frame is 10·CLKS_PER_BIT cycles.
- frame_done is high for the single cycle after the last stop-bit cycle; busy falls on the same edge.
- Back-to-back frames: there is one IDLE cycle between frames, so start edges are 10·CLKS_PER_BIT+1 cycles apart.
- Reset asserted mid-frame: tx goes to 1 and busy to 0 immediately (asynchronously), and the frame is abandoned. After release, the current `cmd` is sent again.

## Test plan
- Bench parameters for all scenarios: CLKS_PER_BIT=4, REFRESH_CYCLES=1000.
- Reset release with power=1, global_state=01, moving_state=0001 → one frame of byte 0x31. The line reads 0 then 1,0,0,0,1,1,0,0 then 1, 4 cycles per bit. frame_done pulses at cycle 41.
- Steady inputs after the first frame → no further start bits until refresh_hit. Keep-alive frames of 0x31 then repeat every 1000 cycles.
- Change moving_state 0001→0100 at frame cycle 10, back to 0001 at cycle 20, and to 1000 at cycle 30 → the first frame completes unchanged. The next frame starts 1 cycle after frame_done and carries 0x38. No 0x34 frame is ever sent.
- power dropped to 0 while idle → tx low on the next edge, frame 0x00. Raise power again with global_state=10, moving_state=0000 → frame 0x50.
- rst asserted at frame cycle 17 for 3 cycles → tx=1 and busy=0 asynchronously. A full frame with the current cmd starts on the first edge after release.
- refresh_hit coinciding with a cmd change in IDLE → exactly one frame; the next frame comes only at the next refresh_hit.
